mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for mem_ack before forced termination (1..255).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ibus_req  input  1  instruction-fetch read request, held until ibus_ack.
REQ-005 SHALL have port ibus_addr  input  32  fetch address.
REQ-006 SHALL have port ibus_rdata  output  32  fetch data, valid with ibus_ack.
REQ-007 SHALL have port ibus_ack  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dbus_req  input  1  data request, held until dbus_ack.
REQ-009 SHALL have port dbus_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port dbus_sel  input  4  byte lane enables.
REQ-011 SHALL have port dbus_addr  input  32  data address.
REQ-012 SHALL have port dbus_wdata  input  32  write data.
REQ-013 SHALL have port dbus_rdata  output  32  read data, valid with dbus_ack.
REQ-014 SHALL have port dbus_ack  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port mem_req  output  1  request to single-port memory.
REQ-016 SHALL have ports mem_we (1), mem_sel (4), mem_addr (32), mem_wdata (32), all output, registered copies of granted requester fields.
REQ-017 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-018 SHALL have port mem_ack  input  1  memory completion, sampled only while mem_req=1.
REQ-019 SHALL have port bus_err_o  output  1  pulses with requester ack when a transaction timed out.

Function
REQ-020 SHALL implement FSM states IDLE, IBUS, DBUS; exactly one transaction outstanding on mem side.
REQ-021 IDLE: ibus_req only -> IBUS; dbus_req only -> DBUS; both -> requester not served last (last_grant flag); neither -> stay.
REQ-022 SHALL latch granted requester's addr/we/sel/wdata into mem_* on grant edge; mem_req=1 from next cycle; ibus grants drive mem_we=0, mem_sel=4'hF, mem_wdata=0.
REQ-023 IBUS/DBUS: mem_req held high, mem_* fields stable, until mem_ack=1 or timeout.
REQ-024 On mem_ack in cycle M: at edge M+1 requester ack=1 for exactly one cycle, rdata latched from mem_rdata (0 for writes), mem_req=0, state IDLE, last_grant updated.
REQ-025 Minimum latency: req sampled at edge N -> mem_req high after N; mem_ack in that first cycle -> ack high after edge N+1; back-to-back grant earliest one cycle after ack (mem_req low for at least one cycle between transactions).
REQ-026 Wait counter SHALL clear on grant, increment each IBUS/DBUS cycle without mem_ack; on reaching TIMEOUT: requester ack=1, bus_err_o=1, rdata=0, mem_req=0, IDLE.
REQ-027 mem_ack and timeout in same cycle SHALL be treated as normal completion (bus_err_o=0).
REQ-028 Requester req still high in cycle after its ack SHALL be treated as a new request, subject to REQ-021.
REQ-029 Requester fields SHALL be ignored except at grant; changes during service do not affect mem_*.
REQ-030 ibus_rdata/dbus_rdata SHALL hold last value between acks.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, last_grant=dbus (ibus wins first tie), counter 0, all outputs 0; in-flight transaction abandoned without ack.
REQ-032 After rst deasserts, first grant SHALL occur no earlier than first rising edge with rst=0.

Verification
REQ-033 ibus_req alone, addr 0x100, mem_ack first cycle with rdata 0xDEADBEEF -> ibus_ack one cycle, ibus_rdata=0xDEADBEEF, two edges after request sampled.
REQ-034 ibus_req and dbus_req together after reset, both held -> order ibus, dbus, ibus, dbus; no overlap of mem_req between grants.
REQ-035 dbus write addr 0x200, sel 4'b0011, wdata 0x12345678, mem_ack after 3 wait cycles -> mem_* stable 4 cycles, dbus_ack, dbus_rdata=0, bus_err_o=0.
REQ-036 TIMEOUT=4, mem_ack never asserted -> after 4 wait cycles ack and bus_err_o pulse together, rdata=0, arbiter accepts next request.
REQ-037 rst asserted mid-DBUS -> mem_req drops without clock edge, no dbus_ack; after release pending ibus_req granted first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two CPU requesters, the single-port memory and the arbiter.
// The slave view belongs to the arbiter; the master view belongs to the surrounding system.
interface mem_arbiter_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_ack;

    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        bus_err_o;

    modport slave (
        input  ibus_req, ibus_addr,
        input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        input  mem_rdata, mem_ack,
        output ibus_rdata, ibus_ack,
        output dbus_rdata, dbus_ack,
        output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output bus_err_o
    );

    modport master (
        output ibus_req, ibus_addr,
        output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        output mem_rdata, mem_ack,
        input  ibus_rdata, ibus_ack,
        input  dbus_rdata, dbus_ack,
        input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  bus_err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port memory.
// One transaction in flight at a time, alternating on ties, with a per-transaction wait timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_e;

    // Last count value a waiting cycle may reach before the transaction is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        lastDbus_q, lastDbus_d;
    logic [7:0]  waitCnt_q, waitCnt_d;

    logic        memWe_q, memWe_d;
    logic [3:0]  memSel_q, memSel_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [31:0] memWdata_q, memWdata_d;

    logic        ibusAck_q, ibusAck_d;
    logic        dbusAck_q, dbusAck_d;
    logic        busErr_q, busErr_d;
    logic [31:0] ibusRdata_q, ibusRdata_d;
    logic [31:0] dbusRdata_q, dbusRdata_d;

    logic        pickIbus;
    logic [31:0] doneRdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lastDbus_q  <= 1'b1;
            waitCnt_q   <= 8'd0;
            memWe_q     <= 1'b0;
            memSel_q    <= 4'h0;
            memAddr_q   <= 32'h0;
            memWdata_q  <= 32'h0;
            ibusAck_q   <= 1'b0;
            dbusAck_q   <= 1'b0;
            busErr_q    <= 1'b0;
            ibusRdata_q <= 32'h0;
            dbusRdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            lastDbus_q  <= lastDbus_d;
            waitCnt_q   <= waitCnt_d;
            memWe_q     <= memWe_d;
            memSel_q    <= memSel_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            ibusAck_q   <= ibusAck_d;
            dbusAck_q   <= dbusAck_d;
            busErr_q    <= busErr_d;
            ibusRdata_q <= ibusRdata_d;
            dbusRdata_q <= dbusRdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lastDbus_d  = lastDbus_q;
        waitCnt_d   = waitCnt_q;
        memWe_d     = memWe_q;
        memSel_d    = memSel_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        ibusAck_d   = 1'b0;
        dbusAck_d   = 1'b0;
        busErr_d    = 1'b0;
        ibusRdata_d = ibusRdata_q;
        dbusRdata_d = dbusRdata_q;

        // On a tie the requester that was not served last wins.
        pickIbus  = bus.ibus_req && (!bus.dbus_req || lastDbus_q);
        // Writes return zero data; reads return what the memory presented.
        doneRdata = (state_q == DBUS && memWe_q) ? 32'h0 : bus.mem_rdata;

        case (state_q)
            IDLE: begin
                waitCnt_d = 8'd0;
                if (pickIbus) begin
                    state_d    = IBUS;
                    memWe_d    = 1'b0;
                    memSel_d   = 4'hF;
                    memAddr_d  = bus.ibus_addr;
                    memWdata_d = 32'h0;
                end else if (bus.dbus_req) begin
                    state_d    = DBUS;
                    memWe_d    = bus.dbus_we;
                    memSel_d   = bus.dbus_sel;
                    memAddr_d  = bus.dbus_addr;
                    memWdata_d = bus.dbus_wdata;
                end
            end
            IBUS, DBUS: begin
                // An ack arriving in the timeout cycle still counts as a normal completion.
                if (bus.mem_ack || waitCnt_q == WAIT_LAST) begin
                    state_d    = IDLE;
                    waitCnt_d  = 8'd0;
                    lastDbus_d = (state_q == DBUS);
                    busErr_d   = !bus.mem_ack;
                    if (state_q == IBUS) begin
                        ibusAck_d   = 1'b1;
                        ibusRdata_d = bus.mem_ack ? doneRdata : 32'h0;
                    end else begin
                        dbusAck_d   = 1'b1;
                        dbusRdata_d = bus.mem_ack ? doneRdata : 32'h0;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req    = (state_q != IDLE);
    assign bus.mem_we     = memWe_q;
    assign bus.mem_sel    = memSel_q;
    assign bus.mem_addr   = memAddr_q;
    assign bus.mem_wdata  = memWdata_q;
    assign bus.ibus_ack   = ibusAck_q;
    assign bus.ibus_rdata = ibusRdata_q;
    assign bus.dbus_ack   = dbusAck_q;
    assign bus.dbus_rdata = dbusRdata_q;
    assign bus.bus_err_o  = busErr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/ordering sequences,
// and a randomized run compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if bif ();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          isDbus;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackCycle;
        logic [31:0] memRdata;
        bit          expWe;
        logic [3:0]  expSel;
        logic [31:0] expWdata;
        int          expAckAt;
        logic [31:0] expRdata;
        bit          expErr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [136:0] getOutputs();
        return {bif.ibus_rdata, bif.ibus_ack, bif.dbus_rdata, bif.dbus_ack, bif.bus_err_o,
                bif.mem_req, bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata};
    endfunction

    task automatic idleInputs();
        bif.ibus_req   = 1'b0;
        bif.ibus_addr  = 32'h0;
        bif.dbus_req   = 1'b0;
        bif.dbus_we    = 1'b0;
        bif.dbus_sel   = 4'h0;
        bif.dbus_addr  = 32'h0;
        bif.dbus_wdata = 32'h0;
        bif.mem_ack    = 1'b0;
        bif.mem_rdata  = 32'h0;
    endtask

    task automatic doReset();
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated transaction from an idle arbiter; memory acks in cycle ackCycle (0 = never).
    task automatic applyStimulus(input vec_t v);
        bit done = 1'b0;
        logic ackI, ackD;
        if (v.isDbus) begin
            bif.dbus_req   = 1'b1;
            bif.dbus_we    = v.we;
            bif.dbus_sel   = v.sel;
            bif.dbus_addr  = v.addr;
            bif.dbus_wdata = v.wdata;
        end else begin
            bif.ibus_req  = 1'b1;
            bif.ibus_addr = v.addr;
            bif.dbus_we    = v.we;
            bif.dbus_sel   = v.sel;
            bif.dbus_wdata = v.wdata;
        end
        bif.mem_ack   = 1'b0;
        bif.mem_rdata = 32'h1111_2222;
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            ackI = bif.ibus_ack;
            ackD = bif.dbus_ack;
            if (ackI || ackD) begin
                checkOutput("ackCycle", 200'(k), 200'(v.expAckAt));
                checkOutput("ackTarget", 200'({ackI, ackD}), 200'(v.isDbus ? 2'b01 : 2'b10));
                checkOutput("rdata", 200'(v.isDbus ? bif.dbus_rdata : bif.ibus_rdata), 200'(v.expRdata));
                checkOutput("busErr", 200'(bif.bus_err_o), 200'(v.expErr));
                checkOutput("memReqDrop", 200'(bif.mem_req), 200'(0));
                bif.ibus_req = 1'b0;
                bif.dbus_req = 1'b0;
                bif.mem_ack  = 1'b0;
                done = 1'b1;
            end else begin
                if (k == 1) checkOutput("memReqRise", 200'(bif.mem_req), 200'(1));
                if (bif.mem_req)
                    checkOutput("memFields",
                                200'({bif.mem_we, bif.mem_sel, bif.mem_addr, bif.mem_wdata}),
                                200'({v.expWe, v.expSel, v.addr, v.expWdata}));
                if (k == 1) begin
                    bif.ibus_addr  = ~v.addr;
                    bif.dbus_addr  = ~v.addr;
                    bif.dbus_wdata = ~v.wdata;
                    bif.dbus_sel   = ~v.sel;
                    bif.dbus_we    = ~v.we;
                end
                bif.mem_ack   = (k == v.ackCycle);
                bif.mem_rdata = (k == v.ackCycle) ? v.memRdata : $urandom;
            end
        end
        if (!done) begin
            checks++;
            $display("[TB] FAIL ackTimeout: got no ack within 12 cycles, expected ack at cycle %0d", v.expAckAt);
            idleInputs();
        end
        @(negedge clk);
        checkOutput("rdataHold", 200'(v.isDbus ? bif.dbus_rdata : bif.ibus_rdata), 200'(v.expRdata));
        checkOutput("ackPulse", 200'({bif.ibus_ack, bif.dbus_ack, bif.bus_err_o}), 200'(0));
    endtask

    vec_t vecs[6];

    // Reference model state for the randomized run.
    bit          mBusy, mWho, mTimedOut, mLastD;
    int          mDone, edgeNo, lat;
    logic [31:0] mAckData;
    logic        eIAck, eDAck, eErr, eWe;
    logic [31:0] eIRdata, eDRdata, eAddr, eWdata;
    logic [3:0]  eSel;

    initial begin
        idleInputs();

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1 checkOutput("resetState", 200'(getOutputs()), 200'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 4'h3, 32'h0000_0100, 32'h0000_0055, 1, 32'hDEAD_BEEF,
                    1'b0, 4'hF, 32'h0, 2, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678, 4, 32'hA5A5_A5A5,
                    1'b1, 4'b0011, 32'h1234_5678, 5, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'hFFFF_FFFF, 0, 32'h0,
                    1'b0, 4'hF, 32'hFFFF_FFFF, 5, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 4'h1, 32'h0000_0404, 32'h0000_0077, 0, 32'h0,
                    1'b0, 4'hF, 32'h0, 5, 32'h0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 4'b0100, 32'h0000_0208, 32'h0000_0001, 2, 32'hCAFE_F00D,
                    1'b0, 4'b0100, 32'h0000_0001, 3, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 4'h2, 32'h0000_010C, 32'h0, 3, 32'h0BAD_F00D,
                    1'b0, 4'hF, 32'h0, 4, 32'h0BAD_F00D, 1'b0};
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Both requesters held from reset: strict alternation starting with ibus.
        begin
            int nGrants = 0;
            int low = 0;
            logic prevReq = 1'b0;
            logic [31:0] order[4];
            int gaps[4];
            doReset();
            bif.ibus_req  = 1'b1;
            bif.ibus_addr = 32'h0000_1000;
            bif.dbus_req  = 1'b1;
            bif.dbus_addr = 32'h0000_2000;
            bif.dbus_sel  = 4'hF;
            for (int c = 0; c < 40 && nGrants < 4; c++) begin
                @(negedge clk);
                if (bif.mem_req && !prevReq) begin
                    order[nGrants] = bif.mem_addr;
                    gaps[nGrants] = low;
                    nGrants++;
                end
                low = bif.mem_req ? 0 : low + 1;
                prevReq = bif.mem_req;
                bif.mem_ack = bif.mem_req;
                bif.mem_rdata = $urandom;
            end
            if (nGrants < 4) begin
                checks++;
                $display("[TB] FAIL grantCount: got %0d grants, expected 4", nGrants);
            end else begin
                checkOutput("order0", 200'(order[0]), 200'(32'h1000));
                checkOutput("order1", 200'(order[1]), 200'(32'h2000));
                checkOutput("order2", 200'(order[2]), 200'(32'h1000));
                checkOutput("order3", 200'(order[3]), 200'(32'h2000));
                for (int g = 1; g < 4; g++) checkOutput("gapCycles", 200'(gaps[g]), 200'(1));
            end
            bif.ibus_req = 1'b0;
            bif.dbus_req = 1'b0;
            @(negedge clk);
            idleInputs();
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of a data transaction, with both requesters pending on release.
        doReset();
        bif.dbus_req  = 1'b1;
        bif.dbus_addr = 32'h0000_3000;
        bif.dbus_sel  = 4'hF;
        @(negedge clk);
        checkOutput("dbusGranted", 200'(bif.mem_req), 200'(1));
        @(negedge clk);
        #2;
        bif.ibus_req  = 1'b1;
        bif.ibus_addr = 32'h0000_4000;
        rst = 1'b1;
        #1 checkOutput("asyncAbort", 200'(getOutputs()), 200'(0));
        repeat (2) @(negedge clk);
        checkOutput("heldInReset", 200'(getOutputs()), 200'(0));
        rst = 1'b0;
        #1 checkOutput("noEarlyGrant", 200'(bif.mem_req), 200'(0));
        @(negedge clk);
        checkOutput("ibusFirstAfterReset",
                    200'({bif.mem_req, bif.mem_we, bif.mem_addr, bif.dbus_ack}),
                    200'({1'b1, 1'b0, 32'h0000_4000, 1'b0}));

        // Randomized traffic against the transaction-level model.
        doReset();
        mBusy = 1'b0; mLastD = 1'b1; edgeNo = 0; mWho = 1'b0; mTimedOut = 1'b0;
        mDone = 0; mAckData = 32'h0;
        eIAck = 1'b0; eDAck = 1'b0; eErr = 1'b0; eWe = 1'b0; eSel = 4'h0;
        eIRdata = 32'h0; eDRdata = 32'h0; eAddr = 32'h0; eWdata = 32'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            edgeNo++;
            eIAck = 1'b0; eDAck = 1'b0; eErr = 1'b0;
            if (mBusy) begin
                if (edgeNo == mDone) begin
                    if (!mWho) begin
                        eIAck = 1'b1;
                        eIRdata = mTimedOut ? 32'h0 : mAckData;
                    end else begin
                        eDAck = 1'b1;
                        eDRdata = (mTimedOut || eWe) ? 32'h0 : mAckData;
                    end
                    eErr = mTimedOut;
                    mLastD = mWho;
                    mBusy = 1'b0;
                end
            end else if (bif.ibus_req || bif.dbus_req) begin
                mWho = (bif.ibus_req && bif.dbus_req) ? !mLastD : bif.dbus_req;
                lat = int'($urandom_range(1, 6));
                mTimedOut = (lat > int'(TIMEOUT));
                mDone = edgeNo + (mTimedOut ? int'(TIMEOUT) : lat);
                mAckData = $urandom;
                mBusy = 1'b1;
                if (mWho) begin
                    eWe = bif.dbus_we; eSel = bif.dbus_sel;
                    eAddr = bif.dbus_addr; eWdata = bif.dbus_wdata;
                end else begin
                    eWe = 1'b0; eSel = 4'hF; eAddr = bif.ibus_addr; eWdata = 32'h0;
                end
            end
            @(negedge clk);
            checkOutput("randomCycle", 200'(getOutputs()),
                        200'({eIRdata, eIAck, eDRdata, eDAck, eErr, mBusy, eWe, eSel, eAddr, eWdata}));
            if (mBusy) bif.mem_ack = !mTimedOut && (edgeNo + 1 == mDone);
            else       bif.mem_ack = ($urandom_range(0, 3) == 0);
            bif.mem_rdata = (mBusy && bif.mem_ack) ? mAckData : $urandom;
            if (eIAck || !bif.ibus_req) begin
                bif.ibus_req  = eIAck ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
                bif.ibus_addr = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                bif.ibus_addr = $urandom;
            end
            if (eDAck || !bif.dbus_req) begin
                bif.dbus_req  = eDAck ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
                bif.dbus_we   = ($urandom_range(0, 1) == 1);
                bif.dbus_sel  = 4'($urandom);
                bif.dbus_addr = $urandom;
                bif.dbus_wdata = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                bif.dbus_we   = ($urandom_range(0, 1) == 1);
                bif.dbus_addr = $urandom;
                bif.dbus_wdata = $urandom;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
